// File: rtl/seg7_pkg.sv
// -----------------------------------------------------------------------------
// seg7_pkg
// Shared definitions for the multiplexed 7-segment driver and its receive-side
// decoder. Segment byte order is {a,b,c,d,e,f,g,dp}, active-low.
//   GLYPHS      : segment codes for hex digits 0..F (dp bit is don't-care)
//   BLANK       : all segments off
//   digit_idx_t : index of one of the four scanned digits
//   anode_one_cold / anode_index : helpers for the active-low anode bus
// -----------------------------------------------------------------------------
package seg7_pkg;

    localparam int NUM_DIGITS = 4;

    localparam logic [7:0] GLYPHS [16] = '{
        8'h03, 8'h9F, 8'h25, 8'h0D,   // 0 1 2 3
        8'h99, 8'h49, 8'h41, 8'h1F,   // 4 5 6 7
        8'h01, 8'h09, 8'h11, 8'hC1,   // 8 9 A b
        8'hE5, 8'h85, 8'h61, 8'h71    // c d E F
    };

    localparam logic [7:0] BLANK = 8'hFF;

    typedef logic [1:0] digit_idx_t;

    // True when exactly one anode line is driven low.
    function automatic logic anode_one_cold(input logic [3:0] an);
        return an inside {4'b1110, 4'b1101, 4'b1011, 4'b0111};
    endfunction

    // Digit selected by a one-cold anode; only meaningful when anode_one_cold().
    function automatic digit_idx_t anode_index(input logic [3:0] an);
        case (an)
            4'b1101: return 2'd1;
            4'b1011: return 2'd2;
            4'b0111: return 2'd3;
            default: return 2'd0;
        endcase
    endfunction

endpackage

// File: rtl/seg7_to_hex.sv
// -----------------------------------------------------------------------------
// seg7_to_hex
// Combinational reverse lookup of a 7-segment pattern (dp excluded).
//   seg   in  [6:0] : segments {a,b,c,d,e,f,g}, active-low
//   hit   out       : pattern is one of the sixteen legal glyphs
//   value out [3:0] : hex value of the matching glyph (0 when no hit)
// -----------------------------------------------------------------------------
module seg7_to_hex
    import seg7_pkg::*;
(
    input  logic [6:0] seg,
    output logic       hit,
    output logic [3:0] value
);

    always_comb begin
        // NOTE: defaults first so every path assigns both outputs; no latch.
        hit   = 1'b0;
        value = 4'h0;
        for (int i = 0; i < 16; i++) begin
            if (seg == GLYPHS[i][7:1]) begin
                hit   = 1'b1;
                value = 4'(i);
            end
        end
    end

endmodule

// File: rtl/seg_scan_decoder.sv
// -----------------------------------------------------------------------------
// seg_scan_decoder
// Recovers the four digits shown on a multiplexed 7-segment display by
// watching its segment and anode lines.
//   clk, rst_n        : clock (rising edge), asynchronous active-low reset
//   seg_in  [7:0]     : active-low segments {a,b,c,d,e,f,g,dp}
//   an_in   [3:0]     : active-low one-cold digit enables (1110 = digit 0)
//   bcd0..bcd3 [3:0]  : last successfully decoded value of each digit
//   digit_valid [3:0] : digit decoded since reset / last watchdog timeout
//   pattern_err [3:0] : most recent capture of the digit was not a glyph
//   frame_done        : one-cycle pulse when all four digits have been seen
//   active            : scan alive; cleared by the no-capture watchdog
// -----------------------------------------------------------------------------
module seg_scan_decoder
    import seg7_pkg::*;
#(
    parameter int STABLE_CYCLES = 16,
    parameter int TIMEOUT_BITS  = 18
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] seg_in,
    input  logic [3:0] an_in,
    output logic [3:0] bcd0,
    output logic [3:0] bcd1,
    output logic [3:0] bcd2,
    output logic [3:0] bcd3,
    output logic [3:0] digit_valid,
    output logic [3:0] pattern_err,
    output logic       frame_done,
    output logic       active
);

    localparam logic [7:0] CNT_LAST = 8'(STABLE_CYCLES - 1);
    localparam logic [7:0] CNT_SAT  = 8'(STABLE_CYCLES);

    logic [11:0]             sync1, s, p;
    logic [7:0]              cnt;
    logic                    capture, valid_cap;
    digit_idx_t              k;
    logic [3:0]              k_mask;
    logic                    hit;
    logic [3:0]              value;
    logic [3:0]              bcd_q [NUM_DIGITS];
    logic [3:0]              seen;
    logic [TIMEOUT_BITS-1:0] wd_cnt;
    logic                    wd_term;

    // Two-flop synchronizer for {an_in, seg_in}.
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value of its source.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= '0;
            s     <= '0;
        end else begin
            sync1 <= {an_in, seg_in};
            s     <= sync1;
        end
    end

    // Stability tracker: count saturates, so a long stable interval yields a
    // single capture.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p   <= '0;
            cnt <= '0;
        end else if (s != p) begin
            p   <= s;
            cnt <= '0;
        end else if (cnt != CNT_SAT) begin
            cnt <= cnt + 8'd1;
        end
    end

    assign capture   = (s == p) && (cnt == CNT_LAST);
    assign valid_cap = capture && anode_one_cold(s[11:8]);
    assign k         = anode_index(s[11:8]);
    assign k_mask    = ~s[11:8];
    assign wd_term   = &wd_cnt;

    seg7_to_hex u_lookup (
        .seg   (s[7:1]),
        .hit   (hit),
        .value (value)
    );

    // Capture registers, frame mask and watchdog. A capture takes priority
    // over the terminal count; the watchdog saturates once expired.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: the digit array is reset explicitly because its reset
            // value is visible on the outputs.
            for (int i = 0; i < NUM_DIGITS; i++) bcd_q[i] <= 4'h0;
            digit_valid <= '0;
            pattern_err <= '0;
            seen        <= '0;
            frame_done  <= 1'b0;
            active      <= 1'b0;
            wd_cnt      <= '0;
        end else begin
            frame_done <= 1'b0;
            if (valid_cap) begin
                wd_cnt <= '0;
                active <= 1'b1;
                if (hit) begin
                    bcd_q[k]       <= value;
                    digit_valid[k] <= 1'b1;
                    pattern_err[k] <= 1'b0;
                end else begin
                    pattern_err[k] <= 1'b1;
                end
                if ((seen | k_mask) == 4'hF) begin
                    frame_done <= 1'b1;
                    seen       <= '0;
                end else begin
                    seen <= seen | k_mask;
                end
            end else if (wd_term) begin
                digit_valid <= '0;
                seen        <= '0;
                active      <= 1'b0;
            end else begin
                wd_cnt <= wd_cnt + 1'b1;
            end
        end
    end

    assign bcd0 = bcd_q[0];
    assign bcd1 = bcd_q[1];
    assign bcd2 = bcd_q[2];
    assign bcd3 = bcd_q[3];

endmodule

// File: doc/seg_scan_decoder.md
# seg_scan_decoder

Receive-side companion to the four-digit multiplexed 7-segment driver. The block samples an active-low segment bus and a one-cold anode bus, waits for each scan slot to settle, decodes the segment pattern back to a 4-bit hex/BCD value, and holds the four recovered digits. It sits in test and inter-board fixtures where a board's display lines are the only observable output, and it provides a frame-complete strobe and a link-alive indication.

## Interface
- `STABLE_CYCLES`, default 16: number of consecutive synchronized cycles `seg_in`/`an_in` must hold before capture; legal range 2..255.
- `TIMEOUT_BITS`, default 18: width of the no-capture watchdog. Timeout at 2^TIMEOUT_BITS−1 cycles, which must exceed one full scan of 4×2^14 clocks.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `seg_in` in 8: active-low segments. [7]=a, [6]=b, [5]=c, [4]=d, [3]=e, [2]=f, [1]=g, [0]=dp.
- `an_in` in 4: active-low digit enables; one-cold selects a digit.
- `bcd0`..`bcd3` out 4 each: recovered digit values; `bcd0` corresponds to `an_in`=1110.
- `digit_valid` out 4: bit k set once digit k has decoded successfully since reset or timeout.
- `pattern_err` out 4: bit k set if the most recent capture of digit k was not a legal glyph.
- `frame_done` out 1: one-cycle pulse when all four digits have been captured since the last pulse.
- `active` out 1: display scan is alive; cleared by the watchdog.

## Operation
- Two-flop synchronizer on all 12 input bits; the later stages see only synchronized sample `s`.
- Stability tracker: `p` holds the previous `s`.
  - If `s`≠`p`: `cnt`←0 and `p`←`s`.
  - Otherwise `cnt` increments, saturating at `STABLE_CYCLES`.
  - Capture fires for exactly one cycle when `s`==`p` and `cnt`==`STABLE_CYCLES`−1.
- At capture, if `an_in` is one-cold (index k):
  - Decode `seg[7:1]`; `dp` is ignored.
  - Legal glyphs: 0=03, 1=9F, 2=25, 3=0D, 4=99, 5=49, 6=41, 7=1F, 8=01, 9=09, A=11, b=C1, c=E5, d=85, E=61, F=71. Match these codes with bit 0 masked.
  - Match: `bcdk`←value, `digit_valid[k]`←1, `pattern_err[k]`←0.
  - No match: `bcdk` is unchanged and `pattern_err[k]`←1.
  - In both cases `seen[k]`←1.
- Capture with `an_in`=1111 or with more than one low bit: ignored completely; no output or mask changes.
- Frame: when a capture makes `seen` equal to 1111, `frame_done` pulses and `seen`←0000 on the same edge. A repeated capture of an already-seen digit updates the value and leaves `seen` unchanged.
- Watchdog:
  - Counts cycles since the last valid-anode capture.
  - At terminal count: `digit_valid`←0, `seen`←0, `active`←0. `bcd*` and `pattern_err` hold.
  - Any valid-anode capture clears the count and sets `active`←1.
  - If a capture and the terminal count occur in the same cycle, the capture wins.

## Timing
- Reset values: `bcd0`..`bcd3`=0, `digit_valid`=0, `pattern_err`=0, `frame_done`=0, `active`=0. All internal counters, `p`, and synchronizer stages are 0. Reset mid-capture discards the pending capture.
- Latency: inputs changed and held before rising edge 1 update the outputs at edge `STABLE_CYCLES`+3. With the default this is edge 19.
- Any input change before that edge restarts the count. Glitches shorter than `STABLE_CYCLES` are never captured.
- Only one capture occurs per stable interval, however long the interval lasts.
- All outputs are registered. `frame_done` is high for exactly one cycle.

## Structure
- Shared package `seg7_pkg`:
  - the 16 glyph constants (bit order as above);
  - the `BLANK`=FF constant;
  - a digit-index type.
  - The driver and this block both use the package.
- Sub-module `seg7_to_hex`: combinational lookup from `seg[7:1]` to {hit, value[3:0]}.
- Synchronizer, stability tracker, capture registers, frame mask, and watchdog stay in the top module.

## Test plan
- Drive `an_in`=1110 with `seg_in`=25 for 40 cycles after reset. Expect `bcd0`=2 and `digit_valid`=0001 at edge 19. Expect no second capture.
- Scan digits 3, 7, A, F across `an_in` 1110→1101→1011→0111, 64 cycles each. Expect `bcd3..0`=F,A,7,3, `frame_done` high for one cycle after the fourth capture, and `active`=1.
- On digit 1, drive `seg_in`=55 for 64 cycles. Expect `pattern_err[1]`=1 and `bcd1` unchanged. A following legal 99 gives `bcd1`=4 and clears the error.
- On digit 0, toggle `seg_in` between 03 and 9F every 8 cycles. Expect no capture. Drive 1111 and 1100 anodes with valid glyphs: expect no change.
- Scan one full frame, then hold `an_in`=1111 for 2^18 cycles. Expect `active`=0, `digit_valid`=0, and `bcd*` retained.
- Assert `rst_n` low asynchronously, mid-stable-count. Expect all outputs to return to their reset values immediately. Expect a fresh capture `STABLE_CYCLES`+3 edges after release with the inputs held.
